vc_input_buffer: RTL

// - Downstream end of the per-VC credit loop: input-port buffer of a router, one FIFO per VC.
// - Accepts flits from the upstream output port and returns one credit per departing flit.

---
 rtl/vc_input_buffer_if.sv | 30 +++
 rtl/vc_input_buffer.sv | 129 ++++++++++++
 2 files changed

// File: rtl/vc_input_buffer_if.sv
// vc_input_buffer_if: flit input, switch grant and head/credit outputs of a VC input buffer
interface vc_input_buffer_if #(
  parameter int FLIT_WIDTH = 64,
  parameter int TIME_WIDTH = 8
);
  logic [FLIT_WIDTH-1:0] flit_in;
  logic                  flit_in_valid;
  logic [1:0]            flit_in_vc;
  logic                  rd_en;
  logic [1:0]            rd_vc;
  logic                  req_out;
  logic [TIME_WIDTH-1:0] time_out;
  logic [1:0]            vc_out;
  logic [FLIT_WIDTH-1:0] flit_out;
  logic                  flit_out_valid;
  logic                  credit_out;
  logic [1:0]            credit_out_vc;
  logic                  overflow_err;
  logic                  underflow_err;
  modport master (
    output flit_in, flit_in_valid, flit_in_vc, rd_en, rd_vc,
    input  req_out, time_out, vc_out, flit_out, flit_out_valid,
           credit_out, credit_out_vc, overflow_err, underflow_err
  );
  modport slave (
    input  flit_in, flit_in_valid, flit_in_vc, rd_en, rd_vc,
    output req_out, time_out, vc_out, flit_out, flit_out_valid,
           credit_out, credit_out_vc, overflow_err, underflow_err
  );
endinterface

// File: rtl/vc_input_buffer.sv
// vc_input_buffer: per-VC input FIFOs with oldest-head selection and credit return
module vc_input_buffer #(
  parameter int FLIT_WIDTH = 64,
  parameter int TIME_WIDTH = 8,
  parameter int TIME_LSB   = 0,
  parameter int NUM_VC     = 4,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 3
) (
  input logic               clk,
  input logic               reset,
  vc_input_buffer_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  typedef logic [PW-1:0]         ptr_t;
  typedef logic [ADDR_WIDTH-1:0] cnt_t;
  typedef logic [TIME_WIDTH-1:0] time_t;
  logic [FLIT_WIDTH-1:0] mem_q [NUM_VC][DEPTH];
  ptr_t                  head_q [NUM_VC];
  ptr_t                  head_d [NUM_VC];
  ptr_t                  tail_q [NUM_VC];
  ptr_t                  tail_d [NUM_VC];
  cnt_t                  cnt_q  [NUM_VC];
  cnt_t                  cnt_d  [NUM_VC];
  time_t                 head_time [NUM_VC];
  logic [NUM_VC-1:0]     wsel;
  logic [NUM_VC-1:0]     rsel;
  logic                  rd_ok;
  logic                  wr_ok;
  logic                  wr_full;
  logic                  rd_empty;
  logic                  sel_any;
  logic [1:0]            sel_vc;
  time_t                 sel_time;
  logic [FLIT_WIDTH-1:0] flit_out_q;
  logic                  flit_out_valid_q;
  logic                  credit_q;
  logic [1:0]            credit_vc_q;
  logic                  ovf_q;
  logic                  unf_q;
  // Reads are judged on the pre-write count, so a same-cycle write never rescues a read of an empty VC;
  // a read of a full VC frees the slot that a same-cycle write to that VC then takes.
  assign rd_empty = cnt_q[bus.rd_vc] == '0;
  assign rd_ok    = bus.rd_en && !rd_empty;
  assign wr_full  = cnt_q[bus.flit_in_vc] == cnt_t'(DEPTH);
  assign wr_ok    = bus.flit_in_valid && (!wr_full || (rd_ok && bus.rd_vc == bus.flit_in_vc));
  genvar g;
  generate
    for (g = 0; g < NUM_VC; g++) begin : g_head
      assign head_time[g] = mem_q[g][head_q[g]][TIME_LSB +: TIME_WIDTH];
    end
  endgenerate
  // Next-state pointers and occupancy per VC; pointers wrap naturally at DEPTH
  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      wsel[v]   = wr_ok && bus.flit_in_vc == 2'(v);
      rsel[v]   = rd_ok && bus.rd_vc == 2'(v);
      head_d[v] = head_q[v] + ptr_t'(rsel[v]);
      tail_d[v] = tail_q[v] + ptr_t'(wsel[v]);
      cnt_d[v]  = cnt_q[v] + cnt_t'(wsel[v]) - cnt_t'(rsel[v]);
    end
  end
  // Oldest non-empty head wins; strict less-than keeps ties on the lowest VC
  always_comb begin
    sel_any  = 1'b0;
    sel_vc   = '0;
    sel_time = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      if (cnt_q[v] != '0 && (!sel_any || head_time[v] < sel_time)) begin
        sel_any  = 1'b1;
        sel_vc   = 2'(v);
        sel_time = head_time[v];
      end
    end
  end
  // FIFO pointers and counts; reset discards everything buffered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int v = 0; v < NUM_VC; v++) begin
        head_q[v] <= '0;
        tail_q[v] <= '0;
        cnt_q[v]  <= '0;
      end
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        head_q[v] <= head_d[v];
        tail_q[v] <= tail_d[v];
        cnt_q[v]  <= cnt_d[v];
      end
    end
  end
  // Flit storage needs no reset: contents are only observed through non-zero counts
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[bus.flit_in_vc][tail_q[bus.flit_in_vc]] <= bus.flit_in;
  end
  // Registered dequeue data and the matching credit pulse, one cycle after the grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flit_out_q       <= '0;
      flit_out_valid_q <= 1'b0;
      credit_q         <= 1'b0;
      credit_vc_q      <= '0;
    end else begin
      flit_out_q       <= rd_ok ? mem_q[bus.rd_vc][head_q[bus.rd_vc]] : flit_out_q;
      flit_out_valid_q <= rd_ok;
      credit_q         <= rd_ok;
      credit_vc_q      <= rd_ok ? bus.rd_vc : '0;
    end
  end
  // Sticky error flags for dropped writes and ignored reads
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q || (bus.flit_in_valid && !wr_ok);
      unf_q <= unf_q || (bus.rd_en && rd_empty);
    end
  end
  assign bus.req_out        = sel_any;
  assign bus.vc_out         = sel_vc;
  assign bus.time_out       = sel_time;
  assign bus.flit_out       = flit_out_q;
  assign bus.flit_out_valid = flit_out_valid_q;
  assign bus.credit_out     = credit_q;
  assign bus.credit_out_vc  = credit_vc_q;
  assign bus.overflow_err   = ovf_q;
  assign bus.underflow_err  = unf_q;
endmodule
